uart_pi_slave: RTL

UART_PI_SLAVE -- requirements
Module: uart_pi_slave

---
 rtl/pi_bus_pkg.sv | 61 ++++++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_pi_slave.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pi_bus_pkg.sv
// -----------------------------------------------------------------------------
// pi_bus_pkg
// Shared definitions for peripherals that sit on the 8-bit CPU port bus.
// Holds the UART block decode constants, the UART register offsets, the
// STATUS/INT_EN bit positions, the TX/RX state encodings, and small helpers
// used by the UART slave.
// -----------------------------------------------------------------------------
package pi_bus_pkg;

    // Block decode: port_id[7:4] selects the block, UART_SEL_BIT is the
    // bit of the one-hot select vector that drives pi_blk_sel.
    localparam logic [3:0] UART_BLK_ADDR = 4'h5;
    localparam int         UART_SEL_BIT  = 5;

    // Register offsets (port_id[3:0])
    localparam logic [3:0] REG_DATA    = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h1;
    localparam logic [3:0] REG_BAUD_LO = 4'h2;
    localparam logic [3:0] REG_BAUD_HI = 4'h3;
    localparam logic [3:0] REG_INT_EN  = 4'h4;

    // STATUS bit positions; [7:5] are the sticky error flags
    localparam int ST_RX_NE    = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_TX_BUSY  = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_FRAME    = 6;
    localparam int ST_TX_OVF   = 7;

    // INT_EN bit positions
    localparam int IE_RX_NE    = 0;
    localparam int IE_TX_EMPTY = 1;
    localparam int IE_ERR      = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // True when a full port_id addresses the UART block.
    function automatic logic uart_blk_decode(input logic [7:0] port_id);
        return (port_id[7:4] == UART_BLK_ADDR);
    endfunction

    // Write-1-to-clear sticky update where a same-cycle set beats the clear.
    function automatic logic sticky_next(input logic cur, input logic clr, input logic set);
        return (cur & ~clr) | set;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. rd_data always shows the head
// entry; pop advances it. A push while full is accepted only when a pop
// happens in the same cycle, otherwise it is dropped and contents are kept.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data   write request and data
//   pop             read request (ignored when empty)
//   rd_data         head entry
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_pi_slave.sv
// -----------------------------------------------------------------------------
// uart_pi_slave
// 8N1 UART with TX/RX FIFOs, exposed as a register slave on the CPU port bus.
// Registers: 0 DATA (W: push TX, R: pop RX), 1 STATUS, 2 BAUD_LO, 3 BAUD_HI,
// 4 INT_EN[2:0]. Bit period is BAUD_DIV+1 clock cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pi_blk_sel, pi_addr      block select and register offset
//   pi_wr_en, pi_wr_data     CPU write strobe and data
//   pi_rd_en, pi_rd_data     CPU read strobe and registered read data
//                            (0x00 whenever the block is not selected)
//   interrupt, interrupt_ack level interrupt to the CPU and its acknowledge
//   uart_txd, uart_rxd       serial line out (idle high) and in (async)
// -----------------------------------------------------------------------------
module uart_pi_slave #(
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd433,
    parameter int          FIFO_DEPTH       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pi_blk_sel,
    input  logic [3:0] pi_addr,
    input  logic       pi_wr_en,
    input  logic       pi_rd_en,
    input  logic [7:0] pi_wr_data,
    output logic [7:0] pi_rd_data,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic       uart_txd,
    input  logic       uart_rxd
);

    import pi_bus_pkg::*;

    // Bus qualifiers
    logic        wr_s;
    logic        rd_s;

    // Control registers
    logic [15:0] baud_div_r;
    logic [2:0]  int_en_r;
    logic        rx_ovr_r;
    logic        frame_err_r;
    logic        tx_ovf_r;
    logic [7:0]  rd_data_r;
    logic        irq_r;
    logic        rx_ne_prev_r;
    logic        tx_empty_prev_r;

    // FIFO interfaces
    logic        tx_push_s;
    logic        tx_pop_s;
    logic        tx_full_s;
    logic        tx_empty_s;
    logic [7:0]  tx_head_s;
    logic        rx_pop_s;
    logic        rx_full_s;
    logic        rx_empty_s;
    logic [7:0]  rx_head_s;

    // TX datapath
    tx_state_t   tx_state_r;
    logic [15:0] tx_cnt_r;
    logic [15:0] tx_div_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        txd_r;
    logic        tx_bit_end_s;

    // RX datapath
    rx_state_t   rx_state_r;
    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic [15:0] rx_cnt_r;
    logic [15:0] rx_div_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_push_r;
    logic        rx_ferr_r;

    // Status, events and read mux
    logic [7:0]  status_s;
    logic [2:0]  sticky_clr_s;
    logic        tx_ovf_set_s;
    logic        rx_ovr_set_s;
    logic        frame_err_set_s;
    logic        irq_event_s;
    logic [7:0]  rd_mux_s;

    assign wr_s = pi_blk_sel & pi_wr_en;
    assign rd_s = pi_blk_sel & pi_rd_en;

    assign tx_push_s = wr_s & (pi_addr == REG_DATA);
    // Reading DATA while RX is empty must not move the FIFO
    assign rx_pop_s  = rd_s & (pi_addr == REG_DATA) & ~rx_empty_s;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_push_s),
        .wr_data (pi_wr_data),
        .pop     (tx_pop_s),
        .rd_data (tx_head_s),
        .full    (tx_full_s),
        .empty   (tx_empty_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_push_r),
        .wr_data (rx_shift_r),
        .pop     (rx_pop_s),
        .rd_data (rx_head_s),
        .full    (rx_full_s),
        .empty   (rx_empty_s)
    );

    // ---------------------------------------------------------------- TX ----
    assign tx_bit_end_s = (tx_cnt_r == tx_div_r);

    // TX FIFO pop: when a frame starts from idle or chains straight after a stop bit
    always_comb begin
        tx_pop_s = 1'b0;
        case (tx_state_r)
            TX_IDLE: tx_pop_s = ~tx_empty_s;
            TX_STOP: tx_pop_s = tx_bit_end_s & ~tx_empty_s;
            default: tx_pop_s = 1'b0;
        endcase
    end

    // TX frame sequencer; the divisor is latched at each frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_div_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (!tx_empty_s) begin
                        tx_state_r <= TX_START;
                        tx_cnt_r   <= 16'd0;
                        tx_div_r   <= baud_div_r;
                        tx_shift_r <= tx_head_s;
                        txd_r      <= 1'b0;
                    end else begin
                        txd_r      <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_bit_end_s) begin
                        tx_state_r <= TX_DATA;
                        tx_cnt_r   <= 16'd0;
                        tx_bit_r   <= 3'd0;
                        txd_r      <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                    end else begin
                        tx_cnt_r   <= tx_cnt_r + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end_s) begin
                        tx_cnt_r <= 16'd0;
                        if (tx_bit_r == 3'd7) begin
                            tx_state_r <= TX_STOP;
                            txd_r      <= 1'b1;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            txd_r      <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end_s) begin
                        tx_cnt_r <= 16'd0;
                        if (!tx_empty_s) begin
                            // Back-to-back frame: start bit follows the stop bit directly
                            tx_state_r <= TX_START;
                            tx_div_r   <= baud_div_r;
                            tx_shift_r <= tx_head_s;
                            txd_r      <= 1'b0;
                        end else begin
                            tx_state_r <= TX_IDLE;
                            txd_r      <= 1'b1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    txd_r      <= 1'b1;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- RX ----
    // RX synchronizer and frame sequencer; the received byte is pushed one
    // cycle after the stop-bit sample, together with its framing flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_div_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_push_r  <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_meta_r <= uart_rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            rx_push_r <= 1'b0;
            rx_ferr_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                        rx_cnt_r   <= 16'd0;
                        rx_div_r   <= baud_div_r;
                    end else begin
                        rx_cnt_r   <= 16'd0;
                    end
                end
                RX_START: begin
                    // Half a bit in: still low means a real start bit
                    if (rx_cnt_r == {1'b0, rx_div_r[15:1]}) begin
                        rx_cnt_r <= 16'd0;
                        rx_bit_r <= 3'd0;
                        if (!rx_sync_r) begin
                            rx_state_r <= RX_DATA;
                        end else begin
                            rx_state_r <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == rx_div_r) begin
                        rx_cnt_r   <= 16'd0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r   <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == rx_div_r) begin
                        rx_cnt_r   <= 16'd0;
                        rx_push_r  <= 1'b1;
                        rx_ferr_r  <= ~rx_sync_r;
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + 16'd1;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= 16'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------ status / irq ----
    assign tx_ovf_set_s    = tx_push_s & tx_full_s & ~tx_pop_s;
    assign rx_ovr_set_s    = rx_push_r & rx_full_s & ~rx_pop_s;
    assign frame_err_set_s = rx_push_r & rx_ferr_r;
    assign sticky_clr_s    = (wr_s && (pi_addr == REG_STATUS)) ? pi_wr_data[7:5] : 3'b000;

    assign status_s[ST_RX_NE]    = ~rx_empty_s;
    assign status_s[ST_RX_FULL]  = rx_full_s;
    assign status_s[ST_TX_EMPTY] = tx_empty_s;
    assign status_s[ST_TX_FULL]  = tx_full_s;
    assign status_s[ST_TX_BUSY]  = (tx_state_r != TX_IDLE);
    assign status_s[ST_RX_OVR]   = rx_ovr_r;
    assign status_s[ST_FRAME]    = frame_err_r;
    assign status_s[ST_TX_OVF]   = tx_ovf_r;

    assign irq_event_s = (int_en_r[IE_RX_NE]    & ~rx_empty_s & ~rx_ne_prev_r) |
                         (int_en_r[IE_TX_EMPTY] & tx_empty_s & ~tx_empty_prev_r) |
                         (int_en_r[IE_ERR]      & (tx_ovf_set_s | rx_ovr_set_s | frame_err_set_s));

    // Read data selection for the addressed register
    always_comb begin
        rd_mux_s = 8'h00;
        case (pi_addr)
            REG_DATA:    rd_mux_s = rx_empty_s ? 8'h00 : rx_head_s;
            REG_STATUS:  rd_mux_s = status_s;
            REG_BAUD_LO: rd_mux_s = baud_div_r[7:0];
            REG_BAUD_HI: rd_mux_s = baud_div_r[15:8];
            REG_INT_EN:  rd_mux_s = {5'b00000, int_en_r};
            default:     rd_mux_s = 8'h00;
        endcase
    end

    // Control registers, sticky flags, read data and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div_r      <= DEFAULT_BAUD_DIV;
            int_en_r        <= 3'b000;
            rx_ovr_r        <= 1'b0;
            frame_err_r     <= 1'b0;
            tx_ovf_r        <= 1'b0;
            rd_data_r       <= 8'h00;
            irq_r           <= 1'b0;
            rx_ne_prev_r    <= 1'b0;
            tx_empty_prev_r <= 1'b1;
        end else begin
            if (wr_s && (pi_addr == REG_BAUD_LO)) begin
                baud_div_r[7:0] <= pi_wr_data;
            end
            if (wr_s && (pi_addr == REG_BAUD_HI)) begin
                baud_div_r[15:8] <= pi_wr_data;
            end
            if (wr_s && (pi_addr == REG_INT_EN)) begin
                int_en_r <= pi_wr_data[2:0];
            end
            rx_ovr_r        <= sticky_next(rx_ovr_r,    sticky_clr_s[0], rx_ovr_set_s);
            frame_err_r     <= sticky_next(frame_err_r, sticky_clr_s[1], frame_err_set_s);
            tx_ovf_r        <= sticky_next(tx_ovf_r,    sticky_clr_s[2], tx_ovf_set_s);
            rd_data_r       <= pi_blk_sel ? rd_mux_s : 8'h00;
            rx_ne_prev_r    <= ~rx_empty_s;
            tx_empty_prev_r <= tx_empty_s;
            // A new event in the acknowledge cycle keeps the request up
            if (irq_event_s) begin
                irq_r <= 1'b1;
            end else if (interrupt_ack) begin
                irq_r <= 1'b0;
            end
        end
    end

    assign pi_rd_data = rd_data_r;
    assign interrupt  = irq_r;
    assign uart_txd   = txd_r;

endmodule
